// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient pattern.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Wide enough for any practical WIDTH; users slice off the low bits.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_sub_stage.sv
// One trial-subtract step of the divider: diff = a - b at WIDTH+1 bits,
// built as a + ~b + 1 on a ripple chain of full-adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module sub_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);
    logic [WIDTH+1:0] carry;
    logic [WIDTH:0]   b_inv;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b_inv[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    // A missing carry-out of a + ~b + 1 means b > a.
    assign borrow = ~carry[WIDTH+1];
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one shift-and-subtract step per clock,
// start/done handshake, results held until the next accepted start.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         dividend,
    input  logic [WIDTH-1:0]         divisor,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         quotient,
    output logic [WIDTH-1:0]         remainder,
    output logic                     div_by_zero,
    output state_t                   state,
    output logic [$clog2(WIDTH):0]   iter_count
);
    // Handshake: start is a request sampled only in IDLE or DONE; an accepted
    // start captures the operands, busy covers the CALC cycles, and done pulses
    // for one cycle when quotient/remainder/div_by_zero become valid.

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, next_state;
    logic [WIDTH-1:0] r_q, q_q, divisor_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   r_sh, trial;
    logic             sub_borrow, no_borrow;
    logic [WIDTH-1:0] r_next, q_next;
    logic             accept, last_iter;

    // R stays below the divisor between iterations, so its top bit is only
    // ever needed in the shifted value fed to the trial subtract.
    assign r_sh = {r_q, q_q[WIDTH-1]};

    sub_stage #(.WIDTH(WIDTH)) u_sub (
        .a     (r_sh),
        .b     ({1'b0, divisor_q}),
        .diff  (trial),
        .borrow(sub_borrow)
    );

    // Carry-out and trial sign agree whenever R < 2*divisor; either flags underflow.
    assign no_borrow = ~sub_borrow & ~trial[WIDTH];
    assign r_next    = no_borrow ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign q_next    = {q_q[WIDTH-2:0], no_borrow};

    assign accept    = start && (state_q != ST_CALC);
    assign last_iter = (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) next_state = (divisor == '0) ? ST_DONE : ST_CALC;
                else       next_state = ST_IDLE;
            end
            ST_CALC: begin
                if (last_iter) next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            divisor_q   <= divisor;
            q_q         <= dividend;
            r_q         <= '0;
            count_q     <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
                quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state_q == ST_CALC) begin
            r_q     <= r_next;
            q_q     <= q_next;
            count_q <= count_q + 1'b1;
            if (last_iter) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end

    assign busy       = (state_q == ST_CALC);
    assign done       = (state_q == ST_DONE);
    assign state      = state_q;
    assign iter_count = count_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset state, known quotients, divide by zero,
// ignored mid-run start, back-to-back start, mid-run reset and a random sweep.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    state_t       state;
    logic [3:0]   iter_count;

    int n_checks = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .state      (state),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge, then inputs scrambled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom_range(0, 255));
        divisor  = W'($urandom_range(0, 255));
    endtask

    // Counts negedges until done, bounded; returns the latency and busy cycles.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int exp_lat, input int exp_busy,
                                input int lat, input int busy_cnt, input logic [W-1:0] exp_q,
                                input logic [W-1:0] exp_r, input logic exp_dbz);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_done"}, done, 1);
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_remainder"}, remainder, exp_r);
        check({tag, "_dbz"}, div_by_zero, exp_dbz);
    endtask

    initial begin
        int lat, bc;
        logic [W-1:0] a, b, eq, er;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_state", state, ST_IDLE);
        check("rst_count", iter_count, 0);
        @(negedge clk);

        // 100 / 7: issue returns at the negedge after the accepting edge.
        issue(8'd100, 8'd7);
        wait_done(lat, bc);
        check_result("d100_7", 8, 8, lat, bc, 8'd14, 8'd2, 1'b0);
        @(negedge clk);
        check("d100_7_done_pulse", done, 0);
        check("d100_7_held_q", quotient, 14);
        check("d100_7_held_r", remainder, 2);

        issue(8'd255, 8'd1);
        wait_done(lat, bc);
        check_result("d255_1", 8, 8, lat, bc, 8'd255, 8'd0, 1'b0);
        @(negedge clk);

        issue(8'd5, 8'd9);
        wait_done(lat, bc);
        check_result("d5_9", 8, 8, lat, bc, 8'd0, 8'd5, 1'b0);
        @(negedge clk);

        issue(8'd200, 8'd200);
        wait_done(lat, bc);
        check_result("d200_200", 8, 8, lat, bc, 8'd1, 8'd0, 1'b0);
        @(negedge clk);

        // Divide by zero completes on the accepting edge, busy never rises.
        issue(8'd42, 8'd0);
        wait_done(lat, bc);
        check_result("d42_0", 0, 0, lat, bc, 8'hFF, 8'd42, 1'b1);
        @(negedge clk);
        check("d42_0_done_pulse", done, 0);
        check("d42_0_held_dbz", div_by_zero, 1);

        // A start pulsed mid-CALC must be ignored.
        issue(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check_result("ignore_mid", 5, 5, lat, bc, 8'd14, 8'd2, 1'b0);

        // Start during the done cycle: no idle bubble.
        issue(8'd50, 8'd3);
        check("b2b_busy", busy, 1);
        wait_done(lat, bc);
        check_result("b2b_50_3", 8, 8, lat, bc, 8'd16, 8'd2, 1'b0);
        @(negedge clk);

        // Reset during the 4th CALC cycle, with start also high: reset wins.
        issue(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        check("midrst_state", state, ST_IDLE);
        check("midrst_count", iter_count, 0);
        issue(8'd9, 8'd2);
        wait_done(lat, bc);
        check_result("d9_2", 8, 8, lat, bc, 8'd4, 8'd1, 1'b0);
        @(negedge clk);

        // Random sweep, back-to-back issue from the done cycle.
        for (int i = 0; i < 400; i++) begin
            a = W'($urandom_range(0, 255));
            b = (i % 25 == 0) ? 8'd0 : W'($urandom_range(1, 255));
            eq = (b == 0) ? 8'hFF : a / b;
            er = (b == 0) ? a : a % b;
            issue(a, b);
            wait_done(lat, bc);
            check("rnd_quotient", quotient, eq);
            check("rnd_remainder", remainder, er);
            check("rnd_latency", lat, (b == 0) ? 0 : 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
